// File: rtl/alu_pkg.sv
// Shared constants, instruction field positions and FSM encoding for the ALU issue controller.
// Optional macro ALU_ISSUE_PIPE_EN adds the EXEC2 state used with a registered-output ALU.
package alu_pkg;

  localparam logic [2:0] ALU_OP_SUB     = 3'b101;
  localparam logic [2:0] ALU_OP_ADD_OVF = 3'b110;

  localparam int INSTR_W = 12;
  localparam int OP_MSB  = 11;
  localparam int OP_LSB  = 9;
  localparam int RD_MSB  = 8;
  localparam int RD_LSB  = 6;
  localparam int RS1_MSB = 5;
  localparam int RS1_LSB = 3;
  localparam int RS2_MSB = 2;
  localparam int RS2_LSB = 0;

  localparam int FLAGS_W    = 3;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_CARRY = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    EXEC  = 3'd2,
`ifdef ALU_ISSUE_PIPE_EN
    EXEC2 = 3'd3,
`endif
    WB    = 3'd4
  } state_t;

  function automatic logic [FLAGS_W-1:0] pack_flags(input logic ovf, input logic zero,
                                                    input logic carry);
    logic [FLAGS_W-1:0] f;
    f             = '0;
    f[FLAG_OVF]   = ovf;
    f[FLAG_ZERO]  = zero;
    f[FLAG_CARRY] = carry;
    return f;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake plus ALU operand/result bus between the issue controller (master)
// and its environment: instruction source and combinational or registered ALU (slave).
interface alu_issue_ctrl_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
);

  // Handshake: an instruction transfers on a rising clk edge where instr_valid && instr_ready.
  // The source keeps instr stable while instr_valid is high and it has not yet been accepted.
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;

  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic [2:0]         alu_op;
  logic [WIDTH-1:0]   alu_result;
  logic               alu_overflow;
  logic               alu_zero;
  logic               alu_carry;

  modport master (
    input  instr_valid, instr, alu_result, alu_overflow, alu_zero, alu_carry,
    output instr_ready, alu_a, alu_b, alu_op
  );

  modport slave (
    output instr_valid, instr, alu_result, alu_overflow, alu_zero, alu_carry,
    input  instr_ready, alu_a, alu_b, alu_op
  );

endinterface

// File: rtl/alu_regfile.sv
// NREGS x WIDTH register file: two async operand read ports, one async debug port,
// one synchronous write port, asynchronous clear on rst.
module alu_regfile #(
  parameter int WIDTH = 32,
  parameter int NREGS = 8,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr_a,
  output logic [WIDTH-1:0] o_rdata_a,
  input  logic [AW-1:0]    i_raddr_b,
  output logic [WIDTH-1:0] o_rdata_b,
  input  logic [AW-1:0]    i_raddr_d,
  output logic [WIDTH-1:0] o_rdata_d
);

  logic [WIDTH-1:0] r_mem [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];
  assign o_rdata_d = r_mem[i_raddr_d];

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts reg-reg instructions, drives ALU operands, writes results and
// flags back. Define ALU_ISSUE_PIPE_EN to add an EXEC2 wait for a registered-output ALU.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 8,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rst,
  alu_issue_ctrl_if.master   bus,
  input  logic               host_we,
  input  logic [AW-1:0]      host_waddr,
  input  logic [WIDTH-1:0]   host_wdata,
  input  logic [AW-1:0]      dbg_raddr,
  output logic [WIDTH-1:0]   dbg_rdata,
  output logic [FLAGS_W-1:0] flags,
  output logic               done,
  output logic               busy,
  output state_t             dbg_state
);

  state_t             r_state;
  logic [INSTR_W-1:0] r_instr;
  logic [WIDTH-1:0]   r_alu_a;
  logic [WIDTH-1:0]   r_alu_b;
  logic [2:0]         r_alu_op;
  logic [WIDTH-1:0]   r_res;
  logic [FLAGS_W-1:0] r_res_flags;
  logic [FLAGS_W-1:0] r_flags;
  logic               r_done;
  logic               r_busy;

  logic [AW-1:0]      w_rd;
  logic [AW-1:0]      w_rs1;
  logic [AW-1:0]      w_rs2;
  logic [WIDTH-1:0]   w_op_a;
  logic [WIDTH-1:0]   w_op_b;
  logic               w_idle;
  logic               w_accept;
  logic               w_rf_we;
  logic [AW-1:0]      w_rf_waddr;
  logic [WIDTH-1:0]   w_rf_wdata;

  assign w_rd  = r_instr[RD_MSB:RD_LSB];
  assign w_rs1 = r_instr[RS1_MSB:RS1_LSB];
  assign w_rs2 = r_instr[RS2_MSB:RS2_LSB];

  assign w_idle   = (r_state == IDLE);
  assign w_accept = w_idle && !host_we && bus.instr_valid;

  // Host writes only land in IDLE; the write-back port owns the rf in WB.
  assign w_rf_we    = (w_idle && host_we) || (r_state == WB);
  assign w_rf_waddr = (r_state == WB) ? w_rd  : host_waddr;
  assign w_rf_wdata = (r_state == WB) ? r_res : host_wdata;

  alu_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_rf_we),
    .i_waddr   (w_rf_waddr),
    .i_wdata   (w_rf_wdata),
    .i_raddr_a (w_rs1),
    .o_rdata_a (w_op_a),
    .i_raddr_b (w_rs2),
    .o_rdata_b (w_op_b),
    .i_raddr_d (dbg_raddr),
    .o_rdata_d (dbg_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_instr     <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_res       <= '0;
      r_res_flags <= '0;
      r_flags     <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_instr <= bus.instr;
            r_state <= ISSUE;
            r_busy  <= 1'b1;
          end
        end
        ISSUE: begin
          r_alu_a  <= w_op_a;
          r_alu_b  <= w_op_b;
          r_alu_op <= r_instr[OP_MSB:OP_LSB];
          r_state  <= EXEC;
        end
`ifdef ALU_ISSUE_PIPE_EN
        EXEC: begin
          r_state <= EXEC2;
        end
        EXEC2: begin
          r_res       <= bus.alu_result;
          r_res_flags <= pack_flags(bus.alu_overflow, bus.alu_zero, bus.alu_carry);
          r_done      <= 1'b1;
          r_state     <= WB;
        end
`else
        EXEC: begin
          r_res       <= bus.alu_result;
          r_res_flags <= pack_flags(bus.alu_overflow, bus.alu_zero, bus.alu_carry);
          r_done      <= 1'b1;
          r_state     <= WB;
        end
`endif
        WB: begin
          r_flags <= r_res_flags;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.instr_ready = w_idle && !host_we;
  assign bus.alu_a       = r_alu_a;
  assign bus.alu_b       = r_alu_b;
  assign bus.alu_op      = r_alu_op;
  assign flags           = r_flags;
  assign done            = r_done;
  assign busy            = r_busy;
  assign dbg_state       = r_state;

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Initiator side of the 32-bit ALU operand/result interface. It accepts 12-bit register-to-register instructions through a valid/ready handshake and reads two source operands from an internal register file. It drives the ALU operand and opcode inputs, then samples the ALU result and overflow/zero/carry flags and writes them back to the register file and a flag register. It sits between the instruction source (or test host) and the combinational ALU.

Parameters:
WIDTH, 32, datapath width; must match the ALU width.
NREGS, 8, register-file depth; the address width is clog2(NREGS) = 3.

Ports:
clk  in  1  clock.
rst  in  1  reset; asynchronous, active-high.
instr_valid  in  1  instruction offered.
instr_ready  out  1  controller can accept an instruction.
instr  in  12  fields {op[11:9], rd[8:6], rs1[5:3], rs2[2:0]}.
host_we  in  1  host register write.
host_waddr  in  3  host write address.
host_wdata  in  WIDTH  host write data.
dbg_raddr  in  3  debug read address.
dbg_rdata  out  WIDTH  combinational read of rf[dbg_raddr].
alu_a  out  WIDTH  operand A, registered.
alu_b  out  WIDTH  operand B, registered.
alu_op  out  3  ALU opcode, registered.
alu_result  in  WIDTH  ALU result.
alu_overflow  in  1  ALU overflow flag.
alu_zero  in  1  ALU zero flag.
alu_carry  in  1  ALU carry flag.
flags  out  3  captured {overflow, zero, carry}.
done  out  1  one-cycle pulse when write-back occurs.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, active-high) has these effects:
  - state = IDLE.
  - All rf entries = 0.
  - alu_a, alu_b, alu_op, flags, done = 0.
  - Any in-flight instruction is discarded with no write-back.
- FSM sequence: IDLE -> ISSUE -> EXEC -> WB -> IDLE.
- IDLE:
  - instr_ready = !host_we.
  - If host_we, rf[host_waddr] <= host_wdata and no instruction is accepted that cycle (host write has priority).
  - Else if instr_valid, latch instr and go to ISSUE.
- ISSUE: alu_a <= rf[rs1], alu_b <= rf[rs2], alu_op <= op. Go to EXEC.
- EXEC: ALU inputs are stable for the whole cycle. At the clock edge, capture alu_result and the three flags into internal holding registers. Go to WB.
- WB:
  - rf[rd] <= captured result.
  - flags <= captured {overflow, zero, carry}.
  - done = 1 for this cycle only. Go to IDLE.
- Latency: the accept edge is followed by done high in the 3rd cycle after it. Peak throughput is 1 instruction per 4 cycles.
- instr_ready = 0 whenever busy.
- host_we outside IDLE is ignored (no write, no error).
- alu_a, alu_b, alu_op hold their last values after WB; they do not return to zero.
- flags hold their value until the next WB.
- rs1 == rs2 is legal; both operands come from the same register.
- rd == rs1 or rd == rs2 is legal; operands are read before write-back.
- Opcode values are forwarded unchanged; the controller does not interpret them.
- Flags are stored exactly as the ALU reports them; the controller does no masking. Carry is already forced to 0 by the ALU for SUB.
- dbg_rdata reflects an rf write on the clock edge after it.

Optional Feature:
Macro ALU_ISSUE_PIPE_EN.
- Defined: an EXEC2 state is inserted after EXEC, and result/flags are sampled at the end of EXEC2. This supports an ALU with a registered output. Latency rises to 4 cycles, throughput to 1 instruction per 5 cycles.
- Undefined: the FSM is exactly as above and the EXEC2 encoding does not exist.

Decomposition:
- Shared package alu_pkg holds:
  - ALU_OP_SUB = 3'b101 and ALU_OP_ADD_OVF = 3'b110. These are the opcodes with defined overflow; ALU_OP_SUB is the carry-masked subtract.
  - The instruction field-position constants.
  - The FSM state enum {IDLE, ISSUE, EXEC, EXEC2, WB}.
  - FLAG_OVF = 2, FLAG_ZERO = 1, FLAG_CARRY = 0.
- One natural sub-module: alu_regfile (NREGS x WIDTH, two async read ports plus the debug port, one sync write port, async clear on rst).

Test Plan:
1. Host writes r1 = 5, r2 = 3, then issue op = 101, rd = 3, rs1 = 1, rs2 = 2 against the real ALU. Expect:
   - alu_a = 5 and alu_b = 3 during EXEC.
   - done 3 cycles after accept.
   - r3 = 2, flags = 3'b000.
2. r1 = 7, r2 = 7, SUB into r4. Expect r4 = 0 and flags = 3'b010 (zero set, carry masked).
3. Bench stub ALU forces result = 0x80000000, overflow = 1, carry = 1. Expect flags = 3'b101 and rd = 0x80000000.
4. Assert instr_valid and host_we together in IDLE. Expect:
   - The host write lands and instr_ready = 0 that cycle.
   - The instruction is accepted on the next cycle.
   - host_we during EXEC leaves the rf unchanged.
5. Assert rst during EXEC. Expect:
   - No done pulse.
   - rf all 0, flags = 0, alu_a/alu_b/alu_op = 0.
   - instr_ready = 1 on the first cycle after rst deasserts.
6. With ALU_ISSUE_PIPE_EN defined, repeat test 1. Expect done 4 cycles after accept and r3 = 2. Back-to-back valid gives one accept every 5 cycles.
